// File: rtl/fp_mul_stream.sv
// fp_mul_stream: valid/ready streaming wrapper with tag and output FIFO around the FPmul core.
// Optional statistics counters are compiled in with `define FP_MUL_STREAM_STATS_EN.
`default_nettype none

// FPmul: single-precision multiplier, round-to-nearest-even, subnormals flushed to zero.
// Result for operands sampled at edge k is on FP_Z after edge k+LAT-1; no reset, no stall.
module FPmul #(
   parameter int LAT = 2
) (
   input  logic        clk,
   input  logic [31:0] FP_A,
   input  logic [31:0] FP_B,
   output logic [31:0] FP_Z
);
   logic [31:0] a_q, b_q, z;
   logic        sa, sb, sz, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [7:0]  ea, eb;
   logic [22:0] ma, mb, mant;
   logic [47:0] prod;
   logic        guard, sticky, inc;
   logic [24:0] rnd;
   logic [9:0]  esum;

   always_ff @(posedge clk) begin
      a_q <= FP_A;
      b_q <= FP_B;
   end

   always_comb begin
      {sa, ea, ma} = a_q;
      {sb, eb, mb} = b_q;
      sz     = sa ^ sb;
      a_nan  = (ea == 8'hFF) && (ma != 23'd0);
      b_nan  = (eb == 8'hFF) && (mb != 23'd0);
      a_inf  = (ea == 8'hFF) && (ma == 23'd0);
      b_inf  = (eb == 8'hFF) && (mb == 23'd0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      prod   = {1'b1, ma} * {1'b1, mb};
      if (prod[47]) begin
         mant   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         mant   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      inc  = guard && (sticky || mant[0]);
      rnd  = {2'b01, mant} + {24'd0, inc};
      // Biased sum still carries one extra bias of 127; range checks are done before removing it.
      esum = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} + {9'd0, rnd[24]};
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         z = 32'h7FC0_0000;
      else if (a_inf || b_inf || (esum >= 10'd382))
         z = {sz, 8'hFF, 23'd0};
      else if (a_zero || b_zero || (esum <= 10'd127))
         z = {sz, 31'd0};
      else
         z = {sz, esum[7:0] - 8'd127, rnd[22:0]};
   end

   generate
      if (LAT == 1) begin : g_lat1
         assign FP_Z = z;
      end else begin : g_pipe
         logic [31:0] z_q [LAT-1];
         always_ff @(posedge clk) begin
            z_q[0] <= z;
            for (int i = 1; i < LAT - 1; i++) z_q[i] <= z_q[i-1];
         end
         assign FP_Z = z_q[LAT-2];
      end
   endgenerate
endmodule

module fp_mul_stream #(
   parameter int LAT        = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
`ifdef FP_MUL_STREAM_STATS_EN
   ,
   output logic [31:0]      stat_issued,
   output logic [31:0]      stat_done,
   output logic [31:0]      stat_stall
`endif
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int EW = 32 + TAG_W;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [LAT-1:0]    vsr_q, vsr_d;
   logic [TAG_W-1:0]  tag_q [LAT];
   logic [CW-1:0]     pending_q, pending_d, cnt_q, cnt_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [EW-1:0]     head;
   logic [31:0]       core_z;
   logic              acc, pop, fifo_wr, flush_run;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   FPmul #(.LAT(LAT)) u_core (
      .clk  (clk),
      .FP_A (in_a),
      .FP_B (in_b),
      .FP_Z (core_z)
   );

   assign in_ready  = (state_q == S_RUN) && (pending_q < CW'(FIFO_DEPTH));
   assign out_valid = (cnt_q != '0);
   assign busy      = (pending_q != '0);
   assign head      = mem_q[rd_ptr_q];
   assign out_data  = out_valid ? head[EW-1:TAG_W] : 32'd0;
   assign out_tag   = out_valid ? head[TAG_W-1:0]  : '0;

   assign acc       = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign fifo_wr   = vsr_q[LAT-1];
   assign flush_run = flush && (state_q == S_RUN);

   always_comb begin
      vsr_d     = (vsr_q << 1) | LAT'(acc);
      pending_d = pending_q;
      cnt_d     = cnt_q;
      wr_ptr_d  = fifo_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      if (acc && !pop)      pending_d = pending_q + CW'(1);
      else if (!acc && pop) pending_d = pending_q - CW'(1);
      if (fifo_wr && !pop)      cnt_d = cnt_q + CW'(1);
      else if (!fifo_wr && pop) cnt_d = cnt_q - CW'(1);
      // Flush drops everything, including a same-edge accept or core write-back.
      if (flush_run) begin
         vsr_d     = '0;
         pending_d = '0;
         cnt_d     = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         vsr_q     <= '0;
         pending_q <= '0;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= S_RUN;
         vsr_q     <= vsr_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      end else begin
         tag_q[0] <= in_tag;
         for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Storage needs no reset: the read side is gated by the count.
   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wr_ptr_q] <= {core_z, tag_q[LAT-1]};
   end

`ifdef FP_MUL_STREAM_STATS_EN
   logic [31:0] issued_q, done_q, stall_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issued_q <= '0;
         done_q   <= '0;
         stall_q  <= '0;
      end else if (flush_run) begin
         issued_q <= '0;
         done_q   <= '0;
         stall_q  <= '0;
      end else begin
         if (acc && (issued_q != 32'hFFFF_FFFF))                      issued_q <= issued_q + 32'd1;
         if (pop && (done_q != 32'hFFFF_FFFF))                        done_q   <= done_q + 32'd1;
         if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF))   stall_q  <= stall_q + 32'd1;
      end
   end

   assign stat_issued = issued_q;
   assign stat_done   = done_q;
   assign stat_stall  = stall_q;
`endif

`ifndef SYNTHESIS
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      !(fifo_wr && (cnt_q == CW'(FIFO_DEPTH)) && !pop))
      else $error("fp_mul_stream: result FIFO written while full");
`endif
endmodule

`default_nettype wire

// File: tb/tb_fp_mul_stream.sv
// Randomized self-checking bench for fp_mul_stream against a queue-based reference model.
`default_nettype none

module tb_fp_mul_stream;
   localparam int LAT = 2;
   localparam int FD  = 4;
   localparam int TW  = 4;

   logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
   logic [31:0]   in_a, in_b, out_data;
   logic [TW-1:0] in_tag, out_tag;
`ifdef FP_MUL_STREAM_STATS_EN
   logic [31:0]   stat_issued, stat_done, stat_stall;
   int unsigned   m_iss, m_done, m_stall;
`endif

   typedef struct {
      logic [31:0]   d;
      logic [TW-1:0] t;
      int            vis;
   } res_t;

   res_t        q[$];
   logic [31:0] cur_prod;
   bit          m_run;
   int          cyc, checks, errors;

   fp_mul_stream #(.LAT(LAT), .FIFO_DEPTH(FD), .TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .busy      (busy)
`ifdef FP_MUL_STREAM_STATS_EN
      ,
      .stat_issued (stat_issued),
      .stat_done   (stat_done),
      .stat_stall  (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value m * 2^e as an IEEE single (m < 2^24 keeps it exact).
   function automatic logic [31:0] mkfp(input bit s, input int unsigned m, input int e);
      int          p;
      int          bexp;
      logic [31:0] mm;
      if (m == 0) return {s, 31'h0};
      p = 0;
      for (int i = 0; i < 32; i++) if (m[i]) p = i;
      bexp = e + p + 127;
      mm   = m << (23 - p);
      return {s, bexp[7:0], mm[22:0]};
   endfunction

   function automatic bit exp_ready();
      return m_run && (q.size() < FD);
   endfunction

   function automatic bit exp_ovalid();
      return (q.size() > 0) && (q[0].vis <= cyc);
   endfunction

   // {in_ready, out_valid, busy, out_data, out_tag} as the model predicts them.
   function automatic logic [38:0] model_out();
      bit v;
      v = exp_ovalid();
      return {exp_ready(), v, q.size() != 0, v ? q[0].d : 32'h0, v ? q[0].t : 4'h0};
   endfunction

   task automatic set_op(input bit sa, input int unsigned ma, input int ea,
                         input bit sb, input int unsigned mb, input int eb, input logic [TW-1:0] tag);
      in_a     = mkfp(sa, ma, ea);
      in_b     = mkfp(sb, mb, eb);
      in_tag   = tag;
      cur_prod = mkfp(sa ^ sb, ma * mb, ea + eb);
   endtask

   task automatic rand_op(input logic [TW-1:0] tag);
      int unsigned ma, mb;
      ma = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4095);
      mb = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 4095);
      set_op(1'($urandom_range(0, 1)), ma, int'($urandom_range(0, 20)) - 10,
             1'($urandom_range(0, 1)), mb, int'($urandom_range(0, 20)) - 10, tag);
   endtask

   // One clock: decide handshakes from the model, advance it across the edge.
   task automatic tick();
      bit a, p, f, st;
      a  = in_valid && exp_ready();
      p  = exp_ovalid() && out_ready;
      st = exp_ovalid() && !out_ready;
      f  = flush && m_run;
      @(posedge clk);
      cyc++;
      if (!rst) begin
         q.delete();
         m_run = 0;
`ifdef FP_MUL_STREAM_STATS_EN
         m_iss = 0; m_done = 0; m_stall = 0;
`endif
      end else if (!m_run) begin
         m_run = 1;
      end else if (f) begin
         q.delete();
`ifdef FP_MUL_STREAM_STATS_EN
         m_iss = 0; m_done = 0; m_stall = 0;
`endif
      end else begin
         if (p) void'(q.pop_front());
         if (a) q.push_back('{d: cur_prod, t: in_tag, vis: cyc + LAT});
`ifdef FP_MUL_STREAM_STATS_EN
         m_iss += a; m_done += p; m_stall += st;
`endif
      end
      #1;
   endtask

   task automatic test_reset();
      repeat (3) begin
         tick();
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== 39'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {in_ready, out_valid, busy, out_data, out_tag});
         end
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle in_ready got %b exp 0", in_ready);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_run in_ready got %b exp 1", in_ready);
      end
   endtask

   task automatic test_single();
      int acc_cyc;
      bit seen;
      seen      = 0;
      out_ready = 1;
      set_op(0, 2, 0, 0, 3, 0, 4'd5);
      in_valid = 1;
      tick();
      acc_cyc  = cyc;
      in_valid = 0;
      repeat (5) begin
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL single cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
         if (out_valid && !seen) begin
            seen = 1;
            checks++;
            if (cyc != acc_cyc + LAT || out_data !== 32'h40C0_0000 || out_tag !== 4'd5) begin
               errors++;
               $display("FAIL single_result got lat=%0d data=%h tag=%0d exp lat=2 data=40c00000 tag=5",
                        cyc - acc_cyc, out_data, out_tag);
            end
         end
         if (cyc == acc_cyc + LAT + 1) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL single_busy got %b exp 0", busy);
            end
         end
         tick();
      end
   endtask

   task automatic test_stream();
      int next_tag;
      next_tag  = 0;
      out_ready = 1;
      for (int k = 0; k < 14; k++) begin
         in_valid = (k < 8);
         if (k < 8) set_op(0, 1, 0, 0, k + 1, 0, TW'(k));
         if (k < 8) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("FAIL stream_ready k=%0d got %b exp 1", k, in_ready);
            end
         end
         if (out_valid) begin
            checks++;
            if (out_tag !== TW'(next_tag) || out_data !== mkfp(0, next_tag + 1, 0)) begin
               errors++;
               $display("FAIL stream_order got tag=%0d data=%h exp tag=%0d data=%h",
                        out_tag, out_data, next_tag, mkfp(0, next_tag + 1, 0));
            end
            next_tag++;
         end
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL stream cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
         tick();
      end
      in_valid = 0;
      checks++;
      if (next_tag != 8) begin
         errors++;
         $display("FAIL stream_count got %0d exp 8", next_tag);
      end
   endtask

   task automatic test_backpressure();
      int idx, dut_acc, budget;
      logic [31:0] held;
      idx = 0; dut_acc = 0; budget = 0;
      out_ready = 0;
      in_valid  = 1;
      rand_op(0);
      repeat (8) begin
         if (in_ready && in_valid) begin
            dut_acc++;
         end
         tick();
         if (exp_ready() || idx < 4) begin
            idx = (idx < 4) ? idx + 1 : idx;
            rand_op(TW'(idx));
         end
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL bp_stall cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
      end
      held = out_data;
      checks++;
      if (dut_acc != 4 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_accepted got %0d ready=%b exp 4 ready=0", dut_acc, in_ready);
      end
      tick();
      checks++;
      if (out_data !== held) begin
         errors++;
         $display("FAIL bp_hold got %h exp %h", out_data, held);
      end
      out_ready = 1;
      while ((idx < 6 || q.size() != 0) && budget < 40) begin
         in_valid = (idx < 6);
         if (in_valid && exp_ready()) begin
            tick();
            idx++;
            rand_op(TW'(idx));
         end else begin
            tick();
         end
         budget++;
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL bp_drain cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
      end
      in_valid = 0;
      checks++;
      if (budget >= 40 || busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_timeout got budget=%0d busy=%b exp drained", budget, busy);
      end
   endtask

   task automatic test_flush();
      out_ready = 0;
      in_valid  = 1;
      for (int i = 0; i < 3; i++) begin
         rand_op(TW'(i));
         tick();
      end
      in_valid = 0;
      flush    = 1;
      tick();
      flush = 0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear got vld=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready);
      end
      out_ready = 1;
      repeat (4) begin
         tick();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stale got out_valid=%b data=%h exp 0", out_valid, out_data);
         end
      end
      set_op(0, 3, -1, 0, 2, 0, 4'd9);
      in_valid = 1;
      tick();
      in_valid = 0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h4040_0000 || out_tag !== 4'd9) begin
         errors++;
         $display("FAIL flush_new got vld=%b data=%h tag=%0d exp 1 40400000 9", out_valid, out_data, out_tag);
      end
      tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         rand_op(TW'($urandom_range(0, 15)));
         tick();
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL random cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
      end
      in_valid = 0; flush = 0; out_ready = 1;
      repeat (8) tick();
   endtask

   task automatic test_async_reset();
      out_ready = 0;
      in_valid  = 1;
      rand_op(1); tick();
      rand_op(2); tick();
      in_valid = 0;
      #2 rst = 1'b0;
      #1;
      q.delete();
      m_run = 0;
`ifdef FP_MUL_STREAM_STATS_EN
      m_iss = 0; m_done = 0; m_stall = 0;
`endif
      checks++;
      if ({in_ready, out_valid, busy, out_data, out_tag} !== 39'h0) begin
         errors++;
         $display("FAIL async_zero got %h exp 0", {in_ready, out_valid, busy, out_data, out_tag});
      end
      tick();
      tick();
      rst = 1'b1;
      out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({in_ready, out_valid, busy, out_data, out_tag} !== model_out()) begin
            errors++;
            $display("FAIL async_release cyc=%0d got %h exp %h", cyc, {in_ready, out_valid, busy, out_data, out_tag}, model_out());
         end
         tick();
      end
   endtask

`ifdef FP_MUL_STREAM_STATS_EN
   task automatic test_stats();
      out_ready = 0;
      flush     = 1;
      tick();
      flush = 0;
      checks++;
      if ({stat_issued, stat_done, stat_stall} !== 96'h0) begin
         errors++;
         $display("FAIL stats_clear got %0d %0d %0d exp 0 0 0", stat_issued, stat_done, stat_stall);
      end
      rand_op(0);
      in_valid = 1;
      tick();
      in_valid = 0;
      repeat (5) tick();
      out_ready = 1;
      for (int i = 1; i < 5; i++) begin
         rand_op(TW'(i));
         in_valid = 1;
         tick();
      end
      in_valid = 0;
      repeat (6) tick();
      checks++;
      if (stat_issued !== 32'd5 || stat_done !== 32'd5 || stat_stall !== 32'd3 ||
          stat_issued !== m_iss || stat_done !== m_done || stat_stall !== m_stall) begin
         errors++;
         $display("FAIL stats_count got %0d %0d %0d exp 5 5 3", stat_issued, stat_done, stat_stall);
      end
      flush = 1;
      tick();
      flush = 0;
      checks++;
      if ({stat_issued, stat_done, stat_stall} !== 96'h0) begin
         errors++;
         $display("FAIL stats_flush got %0d %0d %0d exp 0 0 0", stat_issued, stat_done, stat_stall);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout got no finish exp finish");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; errors = 0; cyc = 0; m_run = 0;
`ifdef FP_MUL_STREAM_STATS_EN
      m_iss = 0; m_done = 0; m_stall = 0;
`endif
      rst = 1'b1; flush = 0; in_valid = 0; out_ready = 0;
      in_a = '0; in_b = '0; in_tag = '0; cur_prod = '0;
      #2 rst = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_flush();
      test_random();
      test_async_reset();
`ifdef FP_MUL_STREAM_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
